rv32i_packet_queue: RTL and testbench

Parametrised N-entry FIFO for `rv32i_packet_t` between CPU pipeline stages. It replaces fixed single-register stage buffers. It adds valid/ready handshaking, configurable depth, and a flush input. The flush either drops entries or converts them to bubbles by clearing the packet's `valid` field. It sits between any two stages, for example IF→ID, and absorbs stalls without losing in-flight packets.

---
 rtl/rv32i_packet_queue_pkg.sv | 16 +
 rtl/rv32i_packet_queue_if.sv | 23 ++
 rtl/rv32i_packet_queue.sv | 88 ++++++++
 tb/tb_rv32i_packet_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_packet_queue_pkg.sv
// Shared types for the rv32i inter-stage packet queue.
package rv32i_packet_queue_pkg;

  // valid must stay the MSB: the queue's bubble flush clears bit WIDTH-1.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } rv32i_packet_t;

  typedef enum logic {FLUSH_DROP, FLUSH_BUBBLE} flush_mode_t;

  localparam int PACKET_WIDTH     = $bits(rv32i_packet_t);
  localparam int PACKET_VALID_BIT = PACKET_WIDTH - 1;

endpackage

// File: rtl/rv32i_packet_queue_if.sv
// Valid/ready handshake bundle on both sides of the packet queue.
interface rv32i_packet_queue_if
  import rv32i_packet_queue_pkg::*;
#(
  parameter int WIDTH = PACKET_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_packet;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_packet;

  modport master (
    output in_valid, in_packet, out_ready,
    input  in_ready, out_valid, out_packet
  );

  modport slave (
    input  in_valid, in_packet, out_ready,
    output in_ready, out_valid, out_packet
  );
endinterface

// File: rtl/rv32i_packet_queue.sv
// DEPTH-entry FIFO between pipeline stages with drop or bubble flush.
// in_ready ignores out_ready, so DEPTH=1 only sustains one packet every two cycles.
module rv32i_packet_queue
  import rv32i_packet_queue_pkg::*;
#(
  parameter int          DEPTH      = 2,
  parameter int          WIDTH      = PACKET_WIDTH,
  parameter flush_mode_t FLUSH_MODE = FLUSH_DROP,
  localparam int         CNT_W      = $clog2(DEPTH + 1),
  localparam int         PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_flush,
  output logic [CNT_W-1:0]     o_count,
  rv32i_packet_queue_if.slave  bus
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_bubble;
  logic             w_wr_en;
  logic [WIDTH-1:0] w_wr_data;

  // Explicit compare so non power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] f_clear_valid(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r            = d;
    r[WIDTH-1]   = 1'b0;
    return r;
  endfunction

  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid & w_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;
  assign w_drop      = rst | (i_flush & (FLUSH_MODE == FLUSH_DROP));
  assign w_bubble    = i_flush & (FLUSH_MODE == FLUSH_BUBBLE);
  assign w_wr_en     = w_push & ~w_drop;
  assign w_wr_data   = w_bubble ? f_clear_valid(bus.in_packet) : bus.in_packet;

  // Storage: no reset, only the valid bit is ever touched by a bubble flush.
  always_ff @(posedge clk) begin
    if (w_bubble) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i][WIDTH-1] <= 1'b0;
      end
    end
    if (w_wr_en) begin
      r_mem[r_tail] <= w_wr_data;
    end
  end

  // Control: reset and drop flush override any push/pop in the same cycle.
  always_ff @(posedge clk) begin
    if (w_drop) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= f_next_ptr(r_tail);
      if (w_pop)  r_head <= f_next_ptr(r_head);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_packet = w_out_valid ? r_mem[r_head] : '0;
  assign o_count        = r_count;

endmodule

// File: tb/tb_rv32i_packet_queue.sv
// Directed bench: three queue instances (D2 drop, D3 drop, D3 bubble) against a queue model.
module tb_rv32i_packet_queue;
  import rv32i_packet_queue_pkg::*;

  localparam int W = PACKET_WIDTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             iv   [3];
  logic             ordy [3];
  logic             fl   [3];
  logic [W-1:0]     pk   [3];
  logic             ir   [3];
  logic             ov   [3];
  logic [W-1:0]     op   [3];
  logic [1:0]       cnt  [3];

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [W-1:0] mq [3][$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    rv32i_packet_queue_if #(.WIDTH(W)) bus ();
    rv32i_packet_queue #(
      .DEPTH      ((g == 0) ? 2 : 3),
      .WIDTH      (W),
      .FLUSH_MODE ((g == 2) ? FLUSH_BUBBLE : FLUSH_DROP)
    ) dut (
      .clk     (clk),
      .rst     (rst),
      .i_flush (fl[g]),
      .o_count (cnt[g]),
      .bus     (bus)
    );
    assign bus.in_valid  = iv[g];
    assign bus.in_packet = pk[g];
    assign bus.out_ready = ordy[g];
    assign ir[g]         = bus.in_ready;
    assign ov[g]         = bus.out_valid;
    assign op[g]         = bus.out_packet;
  end

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 3;
  endfunction

  function automatic logic [W-1:0] P(input int n);
    rv32i_packet_t p;
    p.valid = 1'b1;
    p.pc    = 32'(n * 4);
    p.instr = 32'h0000_0013 ^ 32'(n << 7);
    return p;
  endfunction

  function automatic logic [W-1:0] clr(input logic [W-1:0] d);
    logic [W-1:0] r;
    r        = d;
    r[W-1]   = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[q%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
    end
  endtask

  // Queue model: occupancy-limited FIFO with drop/bubble flush semantics.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int sz;
      bit pu, po;
      logic [W-1:0] t;
      sz = mq[k].size();
      pu = iv[k] && (sz < dep(k));
      po = (sz != 0) && ordy[k];
      if (rst || (fl[k] && k != 2)) begin
        mq[k].delete();
      end else begin
        if (fl[k]) begin
          for (int i = 0; i < sz; i++) begin
            t = mq[k][i];
            mq[k][i] = clr(t);
          end
        end
        if (po) void'(mq[k].pop_front());
        if (pu) mq[k].push_back(fl[k] ? clr(pk[k]) : pk[k]);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        int sz;
        sz = mq[k].size();
        chk("count", k, W'(cnt[k]), W'(sz));
        chk("in_ready", k, W'(ir[k]), W'(sz < dep(k)));
        chk("out_valid", k, W'(ov[k]), W'(sz != 0));
        chk("out_packet", k, op[k], (sz != 0) ? mq[k][0] : '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  logic [17:0] ivt;
  logic [17:0] ort;
  int          nxt;
  int          ex;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; pk[k] = '0;
    end
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_count", 0, W'(cnt[0]), W'(0));
    chk("rst_in_ready", 0, W'(ir[0]), W'(1));
    chk("rst_out_valid", 0, W'(ov[0]), W'(0));
    chk("rst_out_packet", 0, op[0], '0);

    // Fill DEPTH=2 with A, B; C is held off.
    ordy[0] = 1'b0; iv[0] = 1'b1;
    pk[0] = P(1); tick();
    chk("latency_valid", 0, W'(ov[0]), W'(1));
    chk("latency_pkt", 0, op[0], P(1));
    pk[0] = P(2); tick();
    pk[0] = P(3); tick();
    chk("full_count", 0, W'(cnt[0]), W'(2));
    chk("full_in_ready", 0, W'(ir[0]), W'(0));
    chk("full_head", 0, op[0], P(1));
    iv[0] = 1'b0; ordy[0] = 1'b1;
    tick(); tick();
    chk("drained", 0, W'(cnt[0]), W'(0));

    // Streaming at one packet per cycle.
    for (int i = 0; i < 10; i++) begin
      pk[0] = P(i); iv[0] = 1'b1;
      tick();
      chk("stream_pkt", 0, op[0], P(i));
      chk("stream_valid", 0, W'(ov[0]), W'(1));
    end
    iv[0] = 1'b0;
    tick();
    ordy[0] = 1'b0;

    // DEPTH=3 wrap: push 3, pop 2, push 2, pop 2, push+pop 3, drain.
    ivt = 18'b000000_111_00_11_00_111;
    ort = 18'b111111_111_11_00_11_000;
    nxt = 0; ex = 0;
    for (int c = 0; c < 18; c++) begin
      pk[1] = P(100 + nxt); iv[1] = ivt[c]; ordy[1] = ort[c];
      if (ov[1] && ordy[1]) begin
        chk("wrap_order", 1, op[1], P(100 + ex));
        ex++;
      end
      if (iv[1] && ir[1]) nxt++;
      tick();
    end
    iv[1] = 1'b0; ordy[1] = 1'b0;
    chk("wrap_popped", 1, W'(ex), W'(8));
    chk("wrap_empty", 1, W'(cnt[1]), W'(0));

    // Drop flush with simultaneous push.
    iv[0] = 1'b1;
    pk[0] = P(20); tick();
    pk[0] = P(21); tick();
    fl[0] = 1'b1; pk[0] = P(22); tick();
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("drop_count", 0, W'(cnt[0]), W'(0));
    chk("drop_valid", 0, W'(ov[0]), W'(0));
    tick();
    chk("drop_no_ghost", 0, W'(ov[0]), W'(0));

    // Bubble flush with simultaneous push and pop.
    iv[2] = 1'b1;
    pk[2] = P(30); tick();
    pk[2] = P(31); tick();
    fl[2] = 1'b1; pk[2] = P(32); ordy[2] = 1'b1; tick();
    fl[2] = 1'b0; iv[2] = 1'b0; ordy[2] = 1'b0;
    chk("bubble_count", 2, W'(cnt[2]), W'(2));
    chk("bubble_head", 2, op[2], P(31) & {1'b0, {(W-1){1'b1}}});
    ordy[2] = 1'b1; tick();
    chk("bubble_pushed", 2, op[2], P(32) & {1'b0, {(W-1){1'b1}}});
    tick();
    ordy[2] = 1'b0;
    chk("bubble_empty", 2, W'(cnt[2]), W'(0));

    // Reset mid-operation with a pending push.
    iv[0] = 1'b1;
    pk[0] = P(40); tick();
    pk[0] = P(41); tick();
    pk[0] = P(42); rst = 1'b1; tick();
    rst = 1'b0; iv[0] = 1'b0;
    chk("midrst_count", 0, W'(cnt[0]), W'(0));
    chk("midrst_pkt", 0, op[0], '0);
    chk("midrst_in_ready", 0, W'(ir[0]), W'(1));
    tick(); tick();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
